// File: rtl/alu_pkg.sv
// alu_pkg: opcode constants and FSM state encoding shared by alu_ctrl
package alu_pkg;
  localparam logic [1:0] OP_ADD = 2'b00;
  localparam logic [1:0] OP_SUB = 2'b01;
  localparam logic [1:0] OP_NEG = 2'b10;
  localparam logic [1:0] OP_MUL = 2'b11;
  typedef enum logic [1:0] {IDLE, EXEC, MUL, DONE} state_t;
endpackage

// File: rtl/compl1.sv
// compl1: conditional ones' complement (cpl in, ent[W] in, sal[W] out = cpl ? ~ent : ent)
module compl1 #(parameter int W = 4) (
  input  logic         cpl,
  input  logic [W-1:0] ent,
  output logic [W-1:0] sal
);
  assign sal = cpl ? ~ent : ent;
endmodule

// File: rtl/alu_ctrl.sv
// alu_ctrl: handshaked ADD/SUB/NEG in one cycle, MUL by W-step shift-add (clk, rst_n, in_valid/in_ready, op, a, b -> out_valid/out_ready, result, cout, ovf, zero)
module alu_ctrl
  import alu_pkg::*;
#(
  parameter int W = 4
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           in_valid,
  output logic           in_ready,
  input  logic [1:0]     op,
  input  logic [W-1:0]   a,
  input  logic [W-1:0]   b,
  output logic           out_valid,
  input  logic           out_ready,
  output logic [2*W-1:0] result,
  output logic           cout,
  output logic           ovf,
  output logic           zero
);
  localparam int CW = (W > 1) ? $clog2(W) : 1;
  state_t         state;
  logic [1:0]     op_q;
  logic [W-1:0]   a_q, b_q, x, y, yc, sum;
  logic [2*W-1:0] acc, acc_nx;
  logic [CW-1:0]  cnt;
  logic [W:0]     part;
  logic           cpl, c;
  compl1 #(.W(W)) u_compl1 (.cpl(cpl), .ent(y), .sal(yc));
  assign in_ready = state == IDLE;
  always_comb begin
    x = op_q == OP_NEG ? '0 : a_q;
    y = op_q == OP_NEG ? a_q : b_q;
    cpl = op_q != OP_ADD;
    {c, sum} = {1'b0, x} + {1'b0, yc} + {{W{1'b0}}, cpl};
    part = acc[0] ? {1'b0, acc[2*W-1:W]} + {1'b0, a_q} : {1'b0, acc[2*W-1:W]};
    acc_nx = {part, acc[W-1:1]};
  end
  always_ff @(posedge clk)
    if (!rst_n) begin
      state <= IDLE;
      op_q <= OP_ADD;
      a_q <= '0;
      b_q <= '0;
      acc <= '0;
      cnt <= '0;
      result <= '0;
      cout <= 1'b0;
      ovf <= 1'b0;
      zero <= 1'b0;
      out_valid <= 1'b0;
    end else
      case (state)
        IDLE:
          if (in_valid) begin
            op_q <= op;
            a_q <= a;
            b_q <= b;
            acc <= {{W{1'b0}}, b};
            cnt <= '0;
            state <= op == OP_MUL ? MUL : EXEC;
          end
        EXEC: begin
          result <= {{W{1'b0}}, sum};
          cout <= c;
          ovf <= (x[W-1] == yc[W-1]) & (sum[W-1] != x[W-1]);
          zero <= sum == '0;
          out_valid <= 1'b1;
          state <= DONE;
        end
        MUL: begin
          acc <= acc_nx;
          cnt <= cnt + CW'(1);
          if (cnt == CW'(W - 1)) begin
            result <= acc_nx;
            cout <= 1'b0;
            ovf <= acc_nx[2*W-1:W] != '0;
            zero <= acc_nx == '0;
            out_valid <= 1'b1;
            state <= DONE;
          end
        end
        DONE:
          if (out_ready) begin
            out_valid <= 1'b0;
            state <= IDLE;
          end
        default: state <= IDLE;
      endcase
endmodule

// File: tb/tb_alu_ctrl.sv
// tb_alu_ctrl: directed and random checks of alu_ctrl against an arithmetic reference model
module tb_alu_ctrl;
  logic       clk = 1'b0, rst_n = 1'b0, in_valid = 1'b0, out_ready = 1'b0;
  logic [1:0] op = '0;
  logic [3:0] a = '0, b = '0;
  logic       in_ready, out_valid, cout, ovf, zero;
  logic [7:0] result;
  int ncmp = 0, nfail = 0;
  always #5 clk = ~clk;
  alu_ctrl #(.W(4)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready), .op(op), .a(a), .b(b),
    .out_valid(out_valid), .out_ready(out_ready), .result(result), .cout(cout), .ovf(ovf), .zero(zero)
  );
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    ncmp++;
    assert (got === exp) else begin
      nfail++;
      $error("FAIL %s: observed %0d expected %0d", tag, got, exp);
    end
  endtask
  function automatic int sgn(input int v);
    return v >= 8 ? v - 16 : v;
  endfunction
  task automatic model(input int o, input int x, input int y, output int r, output int c, output int v, output int z);
    int s;
    case (o)
      0: begin s = x + y; r = s % 16; c = int'(s >= 16); s = sgn(x) + sgn(y); end
      1: begin r = (x - y + 16) % 16; c = int'(x >= y); s = sgn(x) - sgn(y); end
      2: begin r = (16 - x) % 16; c = int'(x == 0); s = -sgn(x); end
      default: begin r = x * y; c = 0; s = 0; end
    endcase
    v = o == 3 ? int'(r > 15) : int'(s > 7 || s < -8);
    z = int'(r == 0);
  endtask
  task automatic do_op(input int o, input int x, input int y, input int hold);
    int er, ec, eo, ez, lat;
    model(o, x, y, er, ec, eo, ez);
    @(negedge clk);
    chk("in_ready_idle", 32'(in_ready), 1);
    in_valid = 1'b1; op = 2'(o); a = 4'(x); b = 4'(y);
    @(negedge clk);
    chk("in_ready_busy", 32'(in_ready), 0);
    in_valid = 1'($urandom); op = 2'($urandom); a = 4'($urandom); b = 4'($urandom);
    lat = 0;
    while (!out_valid && lat < 20) begin
      @(negedge clk);
      lat++;
      op = 2'($urandom); a = 4'($urandom); b = 4'($urandom);
    end
    chk("latency", 32'(lat), o == 3 ? 4 : 1);
    chk("result", 32'(result), er);
    chk("cout", 32'(cout), ec);
    chk("ovf", 32'(ovf), eo);
    chk("zero", 32'(zero), ez);
    for (int i = 0; i < hold; i++) begin
      in_valid = 1'b1; op = 2'($urandom); a = 4'($urandom); b = 4'($urandom);
      @(negedge clk);
      chk("hold_result", 32'(result), er);
      chk("hold_valid", 32'(out_valid), 1);
      chk("hold_in_ready", 32'(in_ready), 0);
    end
    in_valid = 1'b0; out_ready = 1'b1;
    chk("done_in_ready", 32'(in_ready), 0);
    @(negedge clk);
    out_ready = 1'b0;
    chk("release_valid", 32'(out_valid), 0);
    chk("release_in_ready", 32'(in_ready), 1);
    chk("kept_result", 32'(result), er);
  endtask
  initial begin
    int o, x, y;
    repeat (2) @(negedge clk);
    chk("rst_result", 32'(result), 0);
    chk("rst_valid", 32'(out_valid), 0);
    chk("rst_flags", {29'b0, cout, ovf, zero}, 0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("rst_in_ready", 32'(in_ready), 1);
    do_op(0, 5, 3, 0);
    do_op(1, 5, 5, 0);
    do_op(1, 3, 5, 1);
    do_op(2, 1, 0, 0);
    do_op(2, 8, 0, 0);
    do_op(3, 15, 15, 3);
    @(negedge clk);
    chk("no_second_accept", 32'(in_ready), 1);
    do_op(3, 0, 11, 0);
    do_op(0, 5, 3, 0);
    in_valid = 1'b1; op = 2'd3; a = 4'd15; b = 4'd15;
    @(negedge clk);
    in_valid = 1'b0;
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    chk("abort_result", 32'(result), 0);
    chk("abort_valid", 32'(out_valid), 0);
    chk("abort_flags", {29'b0, cout, ovf, zero}, 0);
    chk("abort_in_ready", 32'(in_ready), 1);
    @(negedge clk);
    chk("post_rst_in_ready", 32'(in_ready), 1);
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      chk("aborted_never_valid", 32'(out_valid), 0);
    end
    for (int i = 0; i < 40; i++) begin
      o = int'($urandom_range(0, 3)); x = int'($urandom_range(0, 15)); y = int'($urandom_range(0, 15));
      do_op(o, x, y, int'($urandom_range(0, 2)));
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
    $finish;
  end
endmodule

// File: doc/alu_ctrl.md
ALU_CTRL -- requirements
Module: alu_ctrl

Interface
REQ-001 SHALL have parameter: W, 4, operand width in bits; result width is 2*W; only W=4 is required to be supported.
REQ-002 SHALL have port: clk  input  1  single clock; all state changes on its rising edge.
REQ-003 SHALL have port: rst_n  input  1  reset, synchronous, active-low.
REQ-004 SHALL have port: in_valid  input  1  request carries a valid operation.
REQ-005 SHALL have port: in_ready  output  1  block can accept a request.
REQ-006 SHALL have port: op  input  2  opcode: 00 ADD, 01 SUB, 10 NEG, 11 MUL.
REQ-007 SHALL have port: a  input  W  first operand.
REQ-008 SHALL have port: b  input  W  second operand (ignored for NEG).
REQ-009 SHALL have port: out_valid  output  1  result and flags valid.
REQ-010 SHALL have port: out_ready  input  1  consumer takes the result.
REQ-011 SHALL have port: result  output  2*W  registered result.
REQ-012 SHALL have port: cout  output  1  carry out of the W-bit adder (SUB: 1 = no borrow).
REQ-013 SHALL have port: ovf  output  1  signed overflow (MUL: product does not fit in W bits, unsigned).
REQ-014 SHALL have port: zero  output  1  result == 0.

Function
REQ-015 SHALL implement FSM states: IDLE, EXEC, MUL, DONE.
REQ-016 SHALL drive in_ready = 1 only in IDLE; a request is accepted on an edge where in_valid & in_ready.
REQ-017 SHALL, on acceptance, latch op, a and b; ADD/SUB/NEG go to EXEC, MUL goes to MUL with iteration count 0.
REQ-018 SHALL, in EXEC, compute x + compl1(y, cpl) + cin in one W-bit add: ADD x=a, y=b, cpl=0, cin=0; SUB x=a, y=b, cpl=1, cin=1; NEG x=0, y=a, cpl=1, cin=1.
REQ-019 SHALL, at the EXEC edge, register result = {W'b0, sum}, cout, ovf = (x[W-1]==y'[W-1]) & (sum[W-1]!=x[W-1]) with y' the complemented operand, zero = (sum==0), and enter DONE; out_valid rises 1 edge after acceptance.
REQ-020 SHALL compute MUL by unsigned shift-add: acc(2W) initialized {W'b0, b}; each MUL cycle, if acc[0] then acc[2W-1:W] += a (with carry); then acc shifts right 1 with the carry entering the MSB.
REQ-021 SHALL perform exactly W MUL iterations, then register result = acc, cout = 0, ovf = (acc[2W-1:W] != 0), zero = (acc == 0), and enter DONE; out_valid rises W edges after acceptance.
REQ-022 SHALL hold out_valid = 1 and result/flags stable in DONE until out_ready = 1; on that edge, return to IDLE.
REQ-023 SHALL keep in_ready = 0 in DONE even when out_ready = 1 (no same-cycle accept); next accept is possible 1 edge later.
REQ-024 SHALL ignore in_valid, op, a and b outside IDLE; latched operands do not change mid-operation.
REQ-025 SHALL keep result/flags at their last value while not in DONE, with out_valid = 0.

Reset
REQ-026 SHALL, on any edge with rst_n = 0, enter IDLE and clear result, cout, ovf, zero, out_valid, the accumulator and the iteration count, aborting any operation in progress.
REQ-027 SHALL drive in_ready = 1 on the first edge after rst_n returns to 1.

Structure
REQ-028 SHALL place the opcode constants (OP_ADD/SUB/NEG/MUL) and the state encoding in the shared package alu_pkg.
REQ-029 SHALL instantiate the existing conditional ones'-complement block compl1 (Sal = cpl ? ~Ent : Ent) for y conditioning; no other sub-module.
REQ-030 SHALL register all outputs except in_ready, which is decoded from state.

Verification
REQ-031 SHALL test: ADD a=0101 b=0011 -> result=00001000, cout=0, ovf=1, zero=0, out_valid 1 edge after accept.
REQ-032 SHALL test: SUB a=0101 b=0101 -> result=00000000, cout=1, ovf=0, zero=1; SUB a=0011 b=0101 -> result=00001110, cout=0.
REQ-033 SHALL test: NEG a=0001 -> result=00001111, ovf=0; NEG a=1000 -> result=00001000, ovf=1.
REQ-034 SHALL test: MUL a=1111 b=1111 -> result=11100001, ovf=1, out_valid exactly 4 edges after accept; MUL a=0000 b=1011 -> zero=1.
REQ-035 SHALL test: hold out_ready=0 for 3 cycles in DONE with in_valid=1 -> result stable, in_ready=0, no second accept; out_ready=1 -> IDLE next edge.
REQ-036 SHALL test: rst_n=0 for 1 edge during MUL iteration 2 -> all outputs 0, in_ready=1 on the following edge, the aborted result is never presented.
